// File: rtl/sync_regfile_pkg.sv
// Shared types and default sizing for the synchronised register file.
package sync_regfile_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_REG_DEPTH  = 256;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    SCAN = 1'b0,
    SEND = 1'b1
  } sync_state_t;

endpackage

// File: rtl/sync_regfile_arbiter_rr_arbiter.sv
// Round-robin write arbiter with a priority override that suppresses all grants.
module rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 override,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int LW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [LW-1:0]        r_last_grant;
  logic [LW-1:0]        w_grant_idx;
  logic [NUM_PORTS-1:0] w_grant;
  logic                 w_found;

  // Two passes: ports above last_grant first, then wrap to the ports at or below it.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = r_last_grant;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && req[i] && (i > int'(r_last_grant))) begin
        w_grant[i]  = 1'b1;
        w_grant_idx = LW'(i);
        w_found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && req[i] && (i <= int'(r_last_grant))) begin
        w_grant[i]  = 1'b1;
        w_grant_idx = LW'(i);
        w_found     = 1'b1;
      end
    end
    if (override) begin
      w_grant     = '0;
      w_grant_idx = r_last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_grant <= LW'(NUM_PORTS - 1);
    end else if (|w_grant) begin
      r_last_grant <= w_grant_idx;
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/sync_regfile_arbiter.sv
// N-port register file with round-robin writes, priority link updates and an outbound sync stream.
// Optional dirty tracking (stream only changed registers) is enabled by SYNC_REGFILE_DIRTY_TRACK_EN.
//
// state | meaning
// SCAN  | walk ptr until an eligible register is found, then latch its address/data
// SEND  | present the latched word on tx until tx_ready
module sync_regfile_arbiter
  import sync_regfile_pkg::*;
#(
  parameter  int NUM_PORTS    = DEF_NUM_PORTS,
  parameter  int REG_DEPTH    = DEF_REG_DEPTH,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int LB_REG_DEPTH = $clog2(REG_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_PORTS-1:0]              m_wvalid,
  input  logic [NUM_PORTS*LB_REG_DEPTH-1:0] m_waddr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_wdata,
  output logic [NUM_PORTS-1:0]              m_wready,
  input  logic [NUM_PORTS-1:0]              m_rreq,
  input  logic [NUM_PORTS*LB_REG_DEPTH-1:0] m_raddr,
  output logic [NUM_PORTS-1:0]              m_rack,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_rdata,
  input  logic                              rx_valid,
  input  logic [LB_REG_DEPTH-1:0]           rx_addr,
  input  logic [DATA_WIDTH-1:0]             rx_data,
  output logic                              rx_ready,
  output logic                              tx_valid,
  output logic [LB_REG_DEPTH-1:0]           tx_addr,
  output logic [DATA_WIDTH-1:0]             tx_data,
  input  logic                              tx_ready
);

  logic [NUM_PORTS-1:0]            w_grant;
  logic                            w_m_we;
  logic [LB_REG_DEPTH-1:0]         w_m_addr;
  logic [DATA_WIDTH-1:0]           w_m_data;
  logic                            w_we;
  logic [LB_REG_DEPTH-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0]           w_wdata;
  logic [DATA_WIDTH-1:0]           r_mem [REG_DEPTH];
  logic [NUM_PORTS-1:0]            r_rack;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata;
  sync_state_t                     r_state, w_state_nxt;
  logic [LB_REG_DEPTH-1:0]         r_ptr, w_ptr_nxt;
  logic [LB_REG_DEPTH-1:0]         r_tx_addr, w_tx_addr_nxt;
  logic [DATA_WIDTH-1:0]           r_tx_data, w_tx_data_nxt;
  logic                            w_elig;
  logic                            w_send_done;

  // Holding the arbiter off during reset keeps m_wready at 0 while rstn is low.
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .req      (m_wvalid),
    .override (rx_valid | ~rstn),
    .grant    (w_grant)
  );

  assign m_wready = w_grant;
  assign rx_ready = rstn;

  always_comb begin
    w_m_we   = 1'b0;
    w_m_addr = '0;
    w_m_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_m_we   = 1'b1;
        w_m_addr = m_waddr[i*LB_REG_DEPTH +: LB_REG_DEPTH];
        w_m_data = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_we    = (rx_valid & rstn) | w_m_we;
  assign w_waddr = rx_valid ? rx_addr : w_m_addr;
  assign w_wdata = rx_valid ? rx_data : w_m_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < REG_DEPTH; k++) r_mem[k] <= '0;
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Reads sample the pre-write array, so a read colliding with a write returns the old value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rack  <= '0;
      r_rdata <= '0;
    end else begin
      r_rack <= m_rreq;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (m_rreq[i]) begin
          r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= r_mem[m_raddr[i*LB_REG_DEPTH +: LB_REG_DEPTH]];
        end
      end
    end
  end

  assign m_rack  = r_rack;
  assign m_rdata = r_rdata;

  assign w_send_done = (r_state == SEND) && tx_ready;

`ifdef SYNC_REGFILE_DIRTY_TRACK_EN
  logic [REG_DEPTH-1:0] r_dirty;

  // Later assignments win: a master set in the same cycle overrides the handshake clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dirty <= '0;
    end else begin
      if (w_send_done) r_dirty[r_tx_addr] <= 1'b0;
      if (rx_valid) begin
        r_dirty[rx_addr] <= 1'b0;
      end else if (w_m_we && (w_m_data != r_mem[w_m_addr])) begin
        r_dirty[w_m_addr] <= 1'b1;
      end
    end
  end

  assign w_elig = r_dirty[r_ptr];
`else
  assign w_elig = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= SCAN;
      r_ptr     <= '0;
      r_tx_addr <= '0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_tx_addr <= w_tx_addr_nxt;
      r_tx_data <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_tx_addr_nxt = r_tx_addr;
    w_tx_data_nxt = r_tx_data;
    case (r_state)
      SCAN: begin
        if (w_elig) begin
          w_tx_addr_nxt = r_ptr;
          w_tx_data_nxt = r_mem[r_ptr];
          w_state_nxt   = SEND;
        end else begin
          w_ptr_nxt = r_ptr + LB_REG_DEPTH'(1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          w_ptr_nxt   = r_ptr + LB_REG_DEPTH'(1);
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  assign tx_valid = (r_state == SEND);
  assign tx_addr  = r_tx_addr;
  assign tx_data  = r_tx_data;

endmodule
